// File: rtl/stream_demux_1x2_if.sv
// Handshake bundle for the 1:2 stream demux: one tagged input stream, two output streams, debug counters.
// slave = demux side, master = source/sink side.
interface stream_demux_1x2_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_sel;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out0_data;
    logic              out0_valid;
    logic              out0_ready;
    logic [DATA_W-1:0] out1_data;
    logic              out1_valid;
    logic              out1_ready;
    logic [CNT_W-1:0]  cnt0;
    logic [CNT_W-1:0]  cnt1;

    modport slave (
        input  in_data, in_sel, in_valid, out0_ready, out1_ready,
        output in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
    );

    modport master (
        output in_data, in_sel, in_valid, out0_ready, out1_ready,
        input  in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
    );
endinterface

// File: rtl/stream_demux_1x2.sv
// Registered 1:2 stream demux steering each word by in_sel into a one-entry slot per channel.
// Latency: 1 cycle from accept to outX_valid; one word per cycle per channel sustained.
// Backpressure: in_ready follows only the addressed slot, so a stalled channel never blocks the other.
module stream_demux_1x2 #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    stream_demux_1x2_if.slave  bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

    slot_t             state0_q, state0_d;
    slot_t             state1_q, state1_d;
    logic [DATA_W-1:0] data0_q, data1_q;
    logic [CNT_W-1:0]  cnt0_q, cnt1_q;
    logic              free0, free1;
    logic              in_ready_int;
    logic              acc0, acc1;
    logic              drain0, drain1;

    // A slot can take a word if it is empty or is being drained this same edge.
    assign free0        = (state0_q == EMPTY) | bus.out0_ready;
    assign free1        = (state1_q == EMPTY) | bus.out1_ready;
    assign in_ready_int = bus.in_sel ? free1 : free0;

    assign acc0   = bus.in_valid & in_ready_int & ~bus.in_sel;
    assign acc1   = bus.in_valid & in_ready_int &  bus.in_sel;
    assign drain0 = (state0_q == FULL) & bus.out0_ready;
    assign drain1 = (state1_q == FULL) & bus.out1_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state0_q <= EMPTY;
            state1_q <= EMPTY;
        end else begin
            state0_q <= state0_d;
            state1_q <= state1_d;
        end
    end

    always_comb begin
        state0_d = state0_q;
        state1_d = state1_q;
        unique case (state0_q)
            EMPTY: if (acc0) state0_d = FULL;
            FULL:  if (drain0 && !acc0) state0_d = EMPTY;
            default: state0_d = EMPTY;
        endcase
        unique case (state1_q)
            EMPTY: if (acc1) state1_d = FULL;
            FULL:  if (drain1 && !acc1) state1_d = EMPTY;
            default: state1_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data0_q <= '0;
            data1_q <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            if (acc0) begin
                data0_q <= bus.in_data;
                cnt0_q  <= cnt0_q + 1'b1;
            end
            if (acc1) begin
                data1_q <= bus.in_data;
                cnt1_q  <= cnt1_q + 1'b1;
            end
        end
    end

    assign bus.in_ready   = in_ready_int;
    assign bus.out0_data  = data0_q;
    assign bus.out0_valid = (state0_q == FULL);
    assign bus.out1_data  = data1_q;
    assign bus.out1_valid = (state1_q == FULL);
    assign bus.cnt0       = cnt0_q;
    assign bus.cnt1       = cnt1_q;
endmodule

// File: tb/tb_stream_demux_1x2.sv
// Directed plus random stimulus for stream_demux_1x2, compared every cycle against a queue-based model.
module tb_stream_demux_1x2;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    logic clk;
    logic reset_n;

    stream_demux_1x2_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    stream_demux_1x2 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    logic [CNT_W-1:0]  m_cnt0;
    logic [CNT_W-1:0]  m_cnt1;
    logic              last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_cnt0 = '0;
        m_cnt1 = '0;
    endtask

    // One clock cycle with the currently driven inputs; checks at negedge, model update at posedge.
    task automatic step();
        logic exp_rdy;
        logic acc;
        logic sel;
        logic [DATA_W-1:0] d;
        logic dr0, dr1;
        @(negedge clk);
        exp_rdy = bus.in_sel ? (q1.size() == 0 || bus.out1_ready)
                             : (q0.size() == 0 || bus.out0_ready);
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("out0_valid", 32'(bus.out0_valid), 32'(q0.size() != 0));
        chk("out1_valid", 32'(bus.out1_valid), 32'(q1.size() != 0));
        if (q0.size() != 0) chk("out0_data", 32'(bus.out0_data), 32'(q0[0]));
        if (q1.size() != 0) chk("out1_data", 32'(bus.out1_data), 32'(q1[0]));
        chk("cnt0", 32'(bus.cnt0), 32'(m_cnt0));
        chk("cnt1", 32'(bus.cnt1), 32'(m_cnt1));
        acc = bus.in_valid && exp_rdy;
        sel = bus.in_sel;
        d   = bus.in_data;
        dr0 = bus.out0_ready;
        dr1 = bus.out1_ready;
        @(posedge clk);
        if (q0.size() != 0 && dr0) void'(q0.pop_front());
        if (q1.size() != 0 && dr1) void'(q1.pop_front());
        if (acc) begin
            if (sel) begin q1.push_back(d); m_cnt1 = m_cnt1 + 1'b1; end
            else     begin q0.push_back(d); m_cnt0 = m_cnt0 + 1'b1; end
        end
        last_acc = acc;
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [DATA_W-1:0] d,
                         input logic r0, input logic r1);
        bus.in_valid   = v;
        bus.in_sel     = s;
        bus.in_data    = d;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
    endtask

    initial begin
        logic [CNT_W-1:0] c0, c1;
        logic held;
        model_reset();
        last_acc = 1'b0;
        reset_n  = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        #2;
        chk("rst_out0_valid", 32'(bus.out0_valid), 32'd0);
        chk("rst_out1_valid", 32'(bus.out1_valid), 32'd0);
        chk("rst_cnt0", 32'(bus.cnt0), 32'd0);
        chk("rst_cnt1", 32'(bus.cnt1), 32'd0);
        chk("rst_out0_data", 32'(bus.out0_data), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;

        // Basic routing
        drive(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1); step();
        chk("basic_out0_valid", 32'(bus.out0_valid), 32'd1);
        chk("basic_out0_data", 32'(bus.out0_data), 32'hA5);
        drive(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1); step();
        chk("basic_out1_valid", 32'(bus.out1_valid), 32'd1);
        chk("basic_out1_data", 32'(bus.out1_data), 32'h3C);
        chk("basic_cnt0", 32'(bus.cnt0), 32'd1);
        chk("basic_cnt1", 32'(bus.cnt1), 32'd1);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1); step();

        // Independent backpressure on channel 1
        drive(1'b1, 1'b1, 8'h11, 1'b1, 1'b0); step();
        drive(1'b1, 1'b1, 8'h44, 1'b1, 1'b0); #1;
        chk("bp_in_ready_sel1", 32'(bus.in_ready), 32'd0);
        step();
        chk("bp_out1_hold", 32'(bus.out1_data), 32'h11);
        drive(1'b1, 1'b0, 8'h22, 1'b1, 1'b0); step();
        chk("bp_out0_22", 32'(bus.out0_data), 32'h22);
        drive(1'b1, 1'b0, 8'h33, 1'b1, 1'b0); step();
        chk("bp_out0_33", 32'(bus.out0_data), 32'h33);
        chk("bp_out1_still", 32'(bus.out1_data), 32'h11);
        chk("bp_out1_valid", 32'(bus.out1_valid), 32'd1);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1); step();

        // Full throughput, alternating channels
        c0 = bus.cnt0; c1 = bus.cnt1;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'(i % 2), 8'($urandom), 1'b1, 1'b1);
            step();
            chk("tp_accept", 32'(last_acc), 32'd1);
        end
        chk("tp_cnt0", 32'(bus.cnt0), 32'(c0 + 8'd8));
        chk("tp_cnt1", 32'(bus.cnt1), 32'(c1 + 8'd8));
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1); step();

        // Same-cycle drain and refill on channel 0
        drive(1'b1, 1'b0, 8'h01, 1'b0, 1'b1); step();
        drive(1'b1, 1'b0, 8'h02, 1'b1, 1'b1); #1;
        chk("refill_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        chk("refill_out0_valid", 32'(bus.out0_valid), 32'd1);
        chk("refill_out0_data", 32'(bus.out0_data), 32'h02);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1); step();

        // Counter wrap on channel 1
        c0 = bus.cnt0; c1 = bus.cnt1;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b1, 8'(i), 1'b1, 1'b1);
            step();
        end
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1); step();
        chk("wrap_cnt1", 32'(bus.cnt1), 32'(c1));
        chk("wrap_cnt0", 32'(bus.cnt0), 32'(c0));

        // Random traffic; an unaccepted word is held by the source
        held = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!held) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_sel   = 1'($urandom);
                bus.in_data  = 8'($urandom);
            end
            bus.out0_ready = 1'($urandom);
            bus.out1_ready = 1'($urandom);
            step();
            held = bus.in_valid && !last_acc;
        end

        // Mid-run reset with both slots full
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1); step();
        drive(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0); step();
        drive(1'b1, 1'b1, 8'hC3, 1'b0, 1'b0); step();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("pre_rst_both_full", 32'({bus.out0_valid, bus.out1_valid}), 32'd3);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out0_valid", 32'(bus.out0_valid), 32'd0);
        chk("mid_rst_out1_valid", 32'(bus.out1_valid), 32'd0);
        chk("mid_rst_out0_data", 32'(bus.out0_data), 32'd0);
        chk("mid_rst_out1_data", 32'(bus.out1_data), 32'd0);
        chk("mid_rst_cnt0", 32'(bus.cnt0), 32'd0);
        chk("mid_rst_cnt1", 32'(bus.cnt1), 32'd0);
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus.in_sel = 1'b0; #1;
        chk("post_rst_ready_sel0", 32'(bus.in_ready), 32'd1);
        bus.in_sel = 1'b1; #1;
        chk("post_rst_ready_sel1", 32'(bus.in_ready), 32'd1);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/stream_demux_1x2.md
Name: stream_demux_1x2

Overview:
- Registered 1-to-2 stream demultiplexer: the receive-side counterpart of the team's 2:1 select path.
- Takes one valid/ready input stream tagged with a select bit and steers each word to one of two output streams.
- Each output channel has a one-entry holding register, so a stalled consumer on one side never corrupts or drops data.
- Per-channel transfer counters support bring-up and debug on the board.

Parameters:
- DATA_W, 8, width of the data word on input and both outputs.
- CNT_W, 8, width of each per-channel accepted-word counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  DATA_W  input word.
- in_sel  input  1  destination: 0 = channel 0, 1 = channel 1.
- in_valid  input  1  input word and in_sel are valid.
- in_ready  output  1  block can accept the word addressed by in_sel this cycle.
- out0_data  output  DATA_W  channel 0 word.
- out0_valid  output  1  channel 0 holds a word.
- out0_ready  input  1  channel 0 consumer accepts.
- out1_data  output  DATA_W  channel 1 word.
- out1_valid  output  1  channel 1 holds a word.
- out1_ready  input  1  channel 1 consumer accepts.
- cnt0  output  CNT_W  words accepted for channel 0.
- cnt1  output  CNT_W  words accepted for channel 1.

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately, no clock needed):
  - out0_valid and out1_valid = 0.
  - out0_data, out1_data, cnt0, cnt1 = 0.
- Reset asserted mid-transfer: held words are discarded and are not replayed after release.
- Per-channel slot state: EMPTY (outX_valid=0) or FULL (outX_valid=1).
- in_ready is combinational: in_ready = in_sel ? (~out1_valid | out1_ready) : (~out0_valid | out0_ready).
  - It depends only on the addressed channel.
  - A stalled channel 1 never blocks words addressed to channel 0, and vice versa.
- Accept event: in_valid & in_ready at a rising edge.
  - Word loaded into channel in_sel; its valid = 1 the next cycle (latency 1 cycle).
  - The other channel's data and valid are unaffected.
- Drain event: outX_valid & outX_ready at a rising edge; the slot goes EMPTY unless refilled in the same cycle.
- Simultaneous drain and accept on the same channel: the slot stays FULL with the new word, giving full throughput of one word per cycle per channel.
- Data stability: while outX_valid=1 and outX_ready=0, outX_data holds its value.
- outX_valid never drops without a handshake, except on reset.
- The block never drops or duplicates a word. Words to the same channel stay in order.
- in_valid=1 with in_ready=0: no state change. The source must hold the word.
- Counters: cntX increments by 1 on each accept event for channel X.
  - Wraps from 2^CNT_W-1 to 0.
  - No saturation, no overflow flag.
- Both outputs can be valid simultaneously. At most one accept per cycle.

Test Plan:
- Reset check: assert reset_n=0 mid-run with both slots FULL -> out0_valid=out1_valid=0, data and counters = 0 with no clock edge. After release, in_ready=1 for either in_sel.
- Basic routing: DATA_W=8, send 0xA5 sel=0 then 0x3C sel=1, both readies high.
  - out0_data=0xA5 with out0_valid one cycle after accept; next cycle out1_data=0x3C.
  - cnt0=1, cnt1=1.
- Independent backpressure: hold out1_ready=0 and send 0x11 sel=1.
  - Further sel=1 words see in_ready=0 and out1_data stays 0x11.
  - Meanwhile 0x22, 0x33 sel=0 pass to out0 on consecutive cycles.
- Full throughput: both readies high, stream 16 words alternating sel.
  - One accept per cycle, in_ready constant 1, each channel receives its 8 words in order.
  - cnt0=cnt1=8.
- Same-cycle drain and refill: channel 0 FULL with 0x01, out0_ready=1, and 0x02 sel=0 offered.
  - Accepted that cycle; next cycle out0_data=0x02 with out0_valid=1.
- Counter wrap: CNT_W=8, accept 256 words on channel 1 -> cnt1 returns to 0, cnt0 unchanged.
